// File: rtl/line_store_responder_if.sv
// Request/response bundle between ctrl_unit (master) and a line-store
// responder (slave).
//   read_request_valid  : single-cycle read request        (master -> slave)
//   write_request_valid : single-cycle write request       (master -> slave)
//   address             : line index, low bits used        (master -> slave)
//   data_d              : write data                       (master -> slave)
//   buffer_addr_valid   : responder ready for traffic      (slave -> master)
//   data_valid          : one-cycle read response pulse    (slave -> master)
//   write_done          : one-cycle write completion pulse (slave -> master)
//   data_q              : read data, held between reads    (slave -> master)
interface line_store_responder_if #(
  parameter int AW = 32,
  parameter int DW = 512
);
  logic          read_request_valid;
  logic          write_request_valid;
  logic [AW-1:0] address;
  logic [DW-1:0] data_d;
  logic          buffer_addr_valid;
  logic          data_valid;
  logic          write_done;
  logic [DW-1:0] data_q;

  modport master (
    output read_request_valid, write_request_valid, address, data_d,
    input  buffer_addr_valid, data_valid, write_done, data_q
  );

  modport slave (
    input  read_request_valid, write_request_valid, address, data_d,
    output buffer_addr_valid, data_valid, write_done, data_q
  );
endinterface

// File: rtl/line_store_responder.sv
// On-chip stand-in for the host-memory path seen by ctrl_unit: an array of
// 2^DEPTH_LOG2 512-bit lines answering one request at a time with fixed
// latency. After reset every line is cleared (one line per cycle) before
// buffer_addr_valid rises and traffic is accepted.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : line_store_responder_if.slave (requests in, pulses/data out)
//
// Timing (cycle T = cycle in which an accepted request is presented):
//   read  : data_valid high in cycle T+READ_LATENCY, data_q updated with it
//   write : line updated and write_done high in cycle T+WRITE_LATENCY
//   The FSM is back in IDLE during the pulse cycle, but requests presented
//   in the pulse cycle are dropped; next acceptance earliest one cycle later.
//
// Optional build macro: LINE_STORE_STALL_INJECT_EN
//   Adds 0..3 extra latency cycles per request from a 16-bit LFSR
//   (x^16+x^14+x^13+x^11+1, seed 16'hACE1). The current LSBs are used by the
//   accepted request, then the LFSR steps.
module line_store_responder #(
  parameter int DEPTH_LOG2    = 6,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  line_store_responder_if.slave bus
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = ((READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY) + 3;
  localparam int LW      = $clog2(MAX_LAT + 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef logic [511:0]          line_t;

  typedef struct packed {
    idx_t  idx;
    line_t data;
  } req_t;

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_WR_WAIT = 2'd3;

  localparam idx_t LAST_LINE = idx_t'(DEPTH - 1);

  logic [1:0]    state;
  idx_t          sweep_cnt;
  logic [LW-1:0] lat_cnt;
  req_t          req_q;
  line_t         mem [DEPTH];

  logic          bav;
  logic          dv;
  logic          wd;
  line_t         q;

  assign bus.buffer_addr_valid = bav;
  assign bus.data_valid        = dv;
  assign bus.write_done        = wd;
  assign bus.data_q            = q;

  // upper address bits alias onto the low index (modulo wrap)
  logic unused_addr;
  assign unused_addr = ^bus.address[31:DEPTH_LOG2];

  logic [1:0] stall;

`ifdef LINE_STORE_STALL_INJECT_EN
  logic [15:0] lfsr;
  assign stall = lfsr[1:0];
`else
  assign stall = 2'b00;
`endif

  logic          accept;
  logic          acc_wr;
  idx_t          acc_idx;
  logic [LW-1:0] lat_sel;
  logic          fire_now;
  logic          fire_wait;
  logic          fire;
  logic          fire_wr;
  idx_t          fire_idx;
  line_t         fire_data;

  always_comb begin
    // write wins when both valids are high; the read is dropped
    acc_wr    = bus.write_request_valid;
    acc_idx   = bus.address[DEPTH_LOG2-1:0];
    // dv/wd high means this is a pulse cycle: requests there are ignored
    accept    = bav && (state == S_IDLE) && !dv && !wd &&
                (bus.read_request_valid || bus.write_request_valid);
    lat_sel   = (acc_wr ? LW'(WRITE_LATENCY) : LW'(READ_LATENCY)) + LW'(stall);
    // latency 1 completes on the acceptance edge itself
    fire_now  = accept && (lat_sel == LW'(1));
    fire_wait = ((state == S_RD_WAIT) || (state == S_WR_WAIT)) && (lat_cnt == LW'(1));
    fire      = fire_now || fire_wait;
    fire_wr   = fire_now ? acc_wr : (state == S_WR_WAIT);
    fire_idx  = fire_now ? acc_idx : req_q.idx;
    fire_data = fire_now ? bus.data_d : req_q.data;
  end

  // line array: cleared by the sweep, written when a write completes
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[sweep_cnt] <= '0;
    else if (fire && fire_wr)
      mem[fire_idx] <= fire_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      lat_cnt   <= '0;
      req_q     <= '0;
      bav       <= 1'b0;
      dv        <= 1'b0;
      wd        <= 1'b0;
      q         <= '0;
    end else begin
      dv <= 1'b0;
      wd <= 1'b0;
      // IDLE is reached only once the sweep is done; ready follows a cycle later
      if (state != S_INIT) bav <= 1'b1;

      case (state)
        S_INIT: begin
          sweep_cnt <= sweep_cnt + idx_t'(1);
          if (sweep_cnt == LAST_LINE) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            req_q.idx  <= acc_idx;
            req_q.data <= bus.data_d;
            if (!fire_now) begin
              state   <= acc_wr ? S_WR_WAIT : S_RD_WAIT;
              lat_cnt <= lat_sel - LW'(1);
            end
          end
        end
        default: begin
          if (lat_cnt == LW'(1)) state <= S_IDLE;
          else                   lat_cnt <= lat_cnt - LW'(1);
        end
      endcase

      if (fire) begin
        if (fire_wr) begin
          wd <= 1'b1;
        end else begin
          dv <= 1'b1;
          q  <= mem[fire_idx];
        end
      end
    end
  end

`ifdef LINE_STORE_STALL_INJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
`endif

endmodule

// File: tb/tb_line_store_responder.sv
// Self-checking bench for line_store_responder. A reference model (line
// array, last read data, latency source) predicts every pulse type, its
// cycle offset from the request cycle and the returned data.
module tb_line_store_responder;
  localparam int DL    = 6;
  localparam int DEPTH = 1 << DL;
  localparam int RL    = 4;
  localparam int WL    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_store_responder_if bus ();

  line_store_responder #(
    .DEPTH_LOG2   (DL),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [511:0] mem_m [DEPTH];
  logic [511:0] q_m;
  logic [15:0]  lfsr_m;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // latency the model expects for the next accepted request
  task automatic model_lat(input bit wr, output int lat);
    lat = wr ? WL : RL;
`ifdef LINE_STORE_STALL_INJECT_EN
    lat += int'(lfsr_m[1:0]);
    lfsr_m = {^(lfsr_m & 16'h002D), lfsr_m[15:1]};
`endif
  endtask

  task automatic clear_inputs();
    bus.read_request_valid  = 1'b0;
    bus.write_request_valid = 1'b0;
    bus.address             = '0;
    bus.data_d              = '0;
  endtask

  task automatic rand_line(output logic [511:0] d);
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
  endtask

  // release reset, hammer requests during the sweep, report ready cycle
  task automatic do_sweep(output int rise, output bit pulsed);
    rise = -1;
    pulsed = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    q_m = '0;
    lfsr_m = 16'hACE1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      if (j < 60) begin
        bus.write_request_valid = 1'b1;
        bus.read_request_valid  = j[0];
        bus.address             = 32'd5;
        bus.data_d              = '1;
      end else begin
        clear_inputs();
      end
      @(posedge clk); #1;
      if (bus.data_valid || bus.write_done) pulsed = 1'b1;
      if (bus.buffer_addr_valid) begin
        rise = j;
        break;
      end
    end
    clear_inputs();
  endtask

  // present one request for one cycle, wait for the first pulse;
  // lat = pulse cycle - request cycle, width_ok = both pulses low next cycle
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [511:0] d, output int lat,
                        output bit got_dv, output bit got_wd, output bit width_ok);
    bus.read_request_valid  = rd;
    bus.write_request_valid = wr;
    bus.address             = addr;
    bus.data_d              = d;
    @(posedge clk); #1;
    clear_inputs();
    lat = -1;
    got_dv = 1'b0;
    got_wd = 1'b0;
    width_ok = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (bus.data_valid || bus.write_done) begin
        got_dv = bus.data_valid;
        got_wd = bus.write_done;
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      width_ok = !bus.data_valid && !bus.write_done;
    end
  endtask

  task automatic test_reset();
    int rise;
    bit pulsed;
    int el, lat;
    bit gdv, gwd, wok;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.buffer_addr_valid !== 1'b0 || bus.data_valid !== 1'b0 ||
        bus.write_done !== 1'b0 || bus.data_q !== 512'd0) begin
      errors++;
      $display("FAIL reset_outputs: got bav=%b dv=%b wd=%b q_nonzero=%b want all 0",
               bus.buffer_addr_valid, bus.data_valid, bus.write_done, |bus.data_q);
    end
    do_sweep(rise, pulsed);
    checks++;
    if (rise !== 65) begin
      errors++;
      $display("FAIL sweep_ready_cycle: got %0d want 65", rise);
    end
    checks++;
    if (pulsed !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_pulse: got pulse=%b want 0", pulsed);
    end
    // line 5 was targeted by writes during the sweep; they must be ignored
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'd5, '0, lat, gdv, gwd, wok);
    q_m = mem_m[5];
    checks++;
    if (lat !== el || gdv !== 1'b1 || gwd !== 1'b0) begin
      errors++;
      $display("FAIL first_read: got lat=%0d dv=%b wd=%b want lat=%0d dv=1 wd=0", lat, gdv, gwd, el);
    end
    checks++;
    if (bus.data_q !== q_m) begin
      errors++;
      $display("FAIL first_read_data: got %h want %h", bus.data_q, q_m);
    end
  endtask

  task automatic test_write_read();
    logic [511:0] d;
    int el, lat;
    bit gdv, gwd, wok;
    d = {16{32'hDEADBEEF}};
    model_lat(1'b1, el);
    run_op(1'b0, 1'b1, 32'd3, d, lat, gdv, gwd, wok);
    mem_m[3] = d;
    checks++;
    if (lat !== el || gwd !== 1'b1 || gdv !== 1'b0 || wok !== 1'b1) begin
      errors++;
      $display("FAIL write3: got lat=%0d wd=%b dv=%b width_ok=%b want lat=%0d wd=1 dv=0 width_ok=1",
               lat, gwd, gdv, wok, el);
    end
    checks++;
    if (bus.data_q !== q_m) begin
      errors++;
      $display("FAIL write3_q_held: got %h want %h", bus.data_q, q_m);
    end
    // issued in the cycle right after the write_done pulse
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'd3, '0, lat, gdv, gwd, wok);
    q_m = mem_m[3];
    checks++;
    if (lat !== el || gdv !== 1'b1 || gwd !== 1'b0 || wok !== 1'b1) begin
      errors++;
      $display("FAIL read3: got lat=%0d dv=%b wd=%b width_ok=%b want lat=%0d dv=1 wd=0 width_ok=1",
               lat, gdv, gwd, wok, el);
    end
    checks++;
    if (bus.data_q !== q_m) begin
      errors++;
      $display("FAIL read3_data: got %h want %h", bus.data_q, q_m);
    end
  endtask

  task automatic test_simultaneous();
    logic [511:0] d;
    int el, lat, wd_at;
    bit gdv, gwd, wok, dv_seen;
    model_lat(1'b1, el);
    run_op(1'b1, 1'b1, 32'd7, 512'h1, lat, gdv, gwd, wok);
    mem_m[7] = 512'h1;
    checks++;
    if (lat !== el || gwd !== 1'b1 || gdv !== 1'b0) begin
      errors++;
      $display("FAIL both_valid: got lat=%0d wd=%b dv=%b want lat=%0d wd=1 dv=0", lat, gwd, gdv, el);
    end
    // write to line 9, then a read of 7 while the write is outstanding
    rand_line(d);
    model_lat(1'b1, el);
    mem_m[9] = d;
    bus.write_request_valid = 1'b1;
    bus.address = 32'd9;
    bus.data_d = d;
    @(posedge clk); #1;
    clear_inputs();
    bus.read_request_valid = 1'b1;
    bus.address = 32'd7;
    @(posedge clk); #1;
    clear_inputs();
    wd_at = -1;
    dv_seen = 1'b0;
    for (int k = 2; k <= 14; k++) begin
      if (bus.write_done && wd_at < 0) wd_at = k;
      if (bus.data_valid) dv_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (wd_at !== el || dv_seen !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop: got wd_at=%0d dv_seen=%b want wd_at=%0d dv_seen=0", wd_at, dv_seen, el);
    end
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'd7, '0, lat, gdv, gwd, wok);
    q_m = mem_m[7];
    checks++;
    if (lat !== el || gdv !== 1'b1 || bus.data_q !== q_m) begin
      errors++;
      $display("FAIL read7_after: got lat=%0d dv=%b q=%h want lat=%0d dv=1 q=%h", lat, gdv, bus.data_q, el, q_m);
    end
  endtask

  task automatic test_wrap();
    int el, lat;
    bit gdv, gwd, wok;
    model_lat(1'b1, el);
    run_op(1'b0, 1'b1, 32'h0000_0041, 512'h55, lat, gdv, gwd, wok);
    mem_m[1] = 512'h55;
    checks++;
    if (lat !== el || gwd !== 1'b1) begin
      errors++;
      $display("FAIL wrap_write: got lat=%0d wd=%b want lat=%0d wd=1", lat, gwd, el);
    end
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'd1, '0, lat, gdv, gwd, wok);
    q_m = mem_m[1];
    checks++;
    if (lat !== el || gdv !== 1'b1 || bus.data_q !== q_m) begin
      errors++;
      $display("FAIL wrap_read1: got lat=%0d dv=%b q=%h want lat=%0d dv=1 q=%h", lat, gdv, bus.data_q, el, q_m);
    end
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'h0000_0040, '0, lat, gdv, gwd, wok);
    q_m = mem_m[0];
    checks++;
    if (lat !== el || gdv !== 1'b1 || bus.data_q !== q_m) begin
      errors++;
      $display("FAIL wrap_read40: got lat=%0d dv=%b q=%h want lat=%0d dv=1 q=%h", lat, gdv, bus.data_q, el, q_m);
    end
  endtask

  task automatic test_random();
    logic [511:0] d;
    logic [31:0]  a;
    int op, el, lat, idx;
    bit rd, wr, gdv, gwd, wok;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      a  = $urandom;
      if (n < 12) a[5:0] = 6'($urandom_range(0, 3));  // collide on a few lines
      idx = int'(a[5:0]);
      rand_line(d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      model_lat(wr, el);
      run_op(rd, wr, a, d, lat, gdv, gwd, wok);
      if (wr) mem_m[idx] = d;
      else    q_m = mem_m[idx];
      checks++;
      if (lat !== el || gdv !== !wr || gwd !== wr || wok !== 1'b1) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: got lat=%0d dv=%b wd=%b width_ok=%b want lat=%0d dv=%b wd=%b width_ok=1",
                 n, lat, gdv, gwd, wok, el, !wr, wr);
      end
      checks++;
      if (bus.data_q !== q_m) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %h want %h", n, bus.data_q, q_m);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [511:0] d;
    int el, lat, rise;
    bit gdv, gwd, wok, pulsed, dv_seen;
    d = {16{32'hA5A5_0F0F}};
    model_lat(1'b1, el);
    run_op(1'b0, 1'b1, 32'd10, d, lat, gdv, gwd, wok);
    mem_m[10] = d;
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'd10, '0, lat, gdv, gwd, wok);
    q_m = mem_m[10];
    checks++;
    if (bus.data_q !== q_m) begin
      errors++;
      $display("FAIL premid_read: got %h want %h", bus.data_q, q_m);
    end
    // accept a read, then drop reset two cycles later between edges
    bus.read_request_valid = 1'b1;
    bus.address = 32'd10;
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.buffer_addr_valid !== 1'b0 || bus.data_valid !== 1'b0 ||
        bus.write_done !== 1'b0 || bus.data_q !== 512'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got bav=%b dv=%b wd=%b q_nonzero=%b want all 0",
               bus.buffer_addr_valid, bus.data_valid, bus.write_done, |bus.data_q);
    end
    dv_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.data_valid || bus.write_done || bus.buffer_addr_valid) dv_seen = 1'b1;
    end
    checks++;
    if (dv_seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got activity=%b want 0", dv_seen);
    end
    do_sweep(rise, pulsed);
    checks++;
    if (rise !== 65 || pulsed !== 1'b0) begin
      errors++;
      $display("FAIL resweep: got rise=%0d pulsed=%b want rise=65 pulsed=0", rise, pulsed);
    end
    model_lat(1'b0, el);
    run_op(1'b1, 1'b0, 32'd10, '0, lat, gdv, gwd, wok);
    q_m = mem_m[10];
    checks++;
    if (lat !== el || gdv !== 1'b1 || bus.data_q !== q_m) begin
      errors++;
      $display("FAIL cleared_line: got lat=%0d dv=%b q=%h want lat=%0d dv=1 q=%h", lat, gdv, bus.data_q, el, q_m);
    end
  endtask

  task automatic test_back_to_back();
    int el, lat, rise, idx;
    bit gdv, gwd, wok, pulsed;
    logic [31:0] a;
    rst_n = 1'b0;
    #23;
    do_sweep(rise, pulsed);
    checks++;
    if (rise !== 65) begin
      errors++;
      $display("FAIL b2b_sweep: got %0d want 65", rise);
    end
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      idx = int'(a[5:0]);
      model_lat(1'b0, el);
      run_op(1'b1, 1'b0, a, '0, lat, gdv, gwd, wok);
      q_m = mem_m[idx];
      checks++;
      if (lat !== el || lat < RL || lat > RL + 3 || gdv !== 1'b1 || gwd !== 1'b0) begin
        errors++;
        $display("FAIL b2b_lat[%0d]: got lat=%0d dv=%b wd=%b want lat=%0d dv=1 wd=0", n, lat, gdv, gwd, el);
      end
      checks++;
      if (bus.data_q !== q_m) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h want %h", n, bus.data_q, q_m);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write_read();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_store_responder.md
Name: line_store_responder

Overview:
- Responder end of the ctrl_unit request interface: read_request_valid / write_request_valid / address / data_d in; data_valid / write_done / data_q / buffer_addr_valid out.
- Backed by an on-chip array of 512-bit lines with programmable fixed latency.
- Drop-in replacement for the host-memory path, so ctrl_unit runs standalone (simulation, bring-up, local scratch).
- Includes a power-up clear sweep before requests are accepted.

Parameters:
- DEPTH_LOG2, 6, log2 of number of 512-bit lines (64 lines).
- READ_LATENCY, 4, cycles from read acceptance to data_valid pulse (legal ≥1).
- WRITE_LATENCY, 2, cycles from write acceptance to write_done pulse (legal ≥1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- read_request_valid  input  1  single-cycle read request.
- write_request_valid  input  1  single-cycle write request.
- address  input  32  line index; only address[DEPTH_LOG2-1:0] used, upper bits ignored (modulo wrap).
- data_d  input  512  write data, sampled with write_request_valid.
- buffer_addr_valid  output  1  high once clear sweep done; responder ready for traffic.
- data_valid  output  1  one-cycle read response pulse.
- write_done  output  1  one-cycle write completion pulse.
- data_q  output  512  read data; valid with data_valid, held until next read response.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: buffer_addr_valid=0, data_valid=0, write_done=0, data_q=0, FSM=INIT, sweep counter=0.
- FSM states: INIT, IDLE, RD_WAIT, WR_WAIT.
- INIT:
  - Writes zero to line[cnt] each cycle, cnt 0..DEPTH-1.
  - After the last line, goes to IDLE and asserts buffer_addr_valid the following cycle. It stays high until reset.
  - Clear takes exactly 2^DEPTH_LOG2 cycles after reset release.
  - Requests during INIT are ignored. No pulses are produced.
- IDLE:
  - A request is accepted on a cycle with buffer_addr_valid=1 and FSM=IDLE.
  - Both valids high in the same cycle: the write wins and the read is dropped silently.
  - Write acceptance: latch index and data_d, go to WR_WAIT.
  - Read acceptance: latch index, go to RD_WAIT.
- Latency counter: loaded at acceptance cycle T.
- Reads:
  - data_valid pulses at T+READ_LATENCY.
  - data_q updates on that same edge with the line contents as of cycle T.
  - Reads never see a write that completes later.
- Writes:
  - The array line is updated at T+WRITE_LATENCY, the same cycle write_done pulses.
  - A read accepted after write_done returns the new data.
- Return to IDLE:
  - FSM returns to IDLE on the pulse cycle.
  - Requests presented in the pulse cycle itself are ignored; the earliest next acceptance is the pulse cycle +1.
- Busy: requests arriving in RD_WAIT/WR_WAIT are dropped. There is no queueing; the initiator waits for the pulse.
- Pulse exclusivity: data_valid and write_done are never high together, and each is exactly 1 cycle wide.
- Address wrap: address 0x0000_0040 with DEPTH_LOG2=6 aliases line 0.
- Reset mid-operation:
  - Asynchronously aborts any pending request (no pulse), clears outputs, returns to INIT.
  - The array is re-cleared by the sweep.

Optional Feature:
- Macro: LINE_STORE_STALL_INJECT_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) steps once per accepted request.
  - Its two LSBs add 0–3 extra cycles to that request's READ_LATENCY or WRITE_LATENCY.
  - Purpose: exercise ctrl_unit tolerance of variable latency.
  - All other rules are unchanged (write visibility at the pulse, busy drop, pulse exclusivity).
- Undefined: latency is exactly the parameter value. No LFSR logic is present.

Test Plan:
- Sweep and ready: release rst_n at cycle 0, DEPTH_LOG2=6 -> buffer_addr_valid rises at cycle 65 (±1 per the INIT rule, checked exactly); read of line 5 -> data_q=0.
- Write then read:
  - Write addr 3, data_d={16{32'hDEADBEEF}} at T -> write_done at T+2.
  - Read addr 3 at T+3 -> data_valid at T+7 with data_q={16{32'hDEADBEEF}}.
- Simultaneous and busy:
  - Read+write both to addr 7 (data 512'h1) in the same cycle -> only write_done pulses.
  - A read issued during WR_WAIT -> no data_valid.
  - A later read of 7 returns 512'h1.
- Wrap: write addr 32'h0000_0041 data 512'h55 -> read addr 1 returns 512'h55.
- Reset mid-read: accept read, drop rst_n at T+2 -> no data_valid, outputs 0 immediately, buffer_addr_valid low until the sweep completes again; previously written line reads 0.
- Stall inject (LINE_STORE_STALL_INJECT_EN): 8 back-to-back reads from reset -> each latency within 4–7.
  - Sequence matches the reference LFSR model from seed 16'hACE1.
  - data_q is correct for each read.
